// File: rtl/traffic_light_ctrl.sv
// Main/side road traffic light with pedestrian crossing: a Moore FSM whose state
// durations are counted in prescaled ticks.
module traffic_light_ctrl #(
  parameter int unsigned CLK_DIV   = 100000000,
  parameter int unsigned T_GREEN_M = 10,
  parameter int unsigned T_GREEN_S = 6,
  parameter int unsigned T_YELLOW  = 3,
  parameter int unsigned T_WALK    = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] state
);

  localparam int unsigned PW = 16;
  localparam int unsigned TW = 8;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_MG   = 3'd0;
  localparam logic [SW-1:0] S_MY   = 3'd1;
  localparam logic [SW-1:0] S_SG   = 3'd2;
  localparam logic [SW-1:0] S_SY   = 3'd3;
  localparam logic [SW-1:0] S_WALK = 3'd4;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [SW-1:0] cur_state;
  logic [SW-1:0] nxt_state;
  logic [PW-1:0] presc;
  logic [TW-1:0] timer;
  logic [TW-1:0] t_last;
  logic          tick;
  logic          done;
  logic          trans;
  logic          ped_q;

  assign tick  = (presc == PRESC_LAST);
  assign done  = tick && (timer == t_last);
  assign trans = (nxt_state != cur_state);

  // Last timer value of the current state
  always_comb begin
    t_last = TW'(T_GREEN_M - 1);
    case (cur_state)
      S_MY:    t_last = TW'(T_YELLOW - 1);
      S_SG:    t_last = TW'(T_GREEN_S - 1);
      S_SY:    t_last = TW'(T_YELLOW - 1);
      S_WALK:  t_last = TW'(T_WALK - 1);
      default: t_last = TW'(T_GREEN_M - 1);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur_state <= S_MG;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; illegal codes recover to MG on the next clock
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_MG:    if (done) nxt_state = S_MY;
      S_MY:    if (done) nxt_state = S_SG;
      S_SG:    if (done) nxt_state = S_SY;
      S_SY:    if (done) nxt_state = ped_q ? S_WALK : S_MG;
      S_WALK:  if (done) nxt_state = S_MG;
      default: nxt_state = S_MG;
    endcase
  end

  // Lamp decode; illegal codes show MG lamps
  always_comb begin
    main_light = LAMP_G;
    side_light = LAMP_R;
    walk       = 1'b0;
    case (cur_state)
      S_MY: begin
        main_light = LAMP_Y;
      end
      S_SG: begin
        main_light = LAMP_R;
        side_light = LAMP_G;
      end
      S_SY: begin
        main_light = LAMP_R;
        side_light = LAMP_Y;
      end
      S_WALK: begin
        main_light = LAMP_R;
        walk       = 1'b1;
      end
      default: ;
    endcase
  end

  // Prescaler and tick timer restart on every state change
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      timer <= '0;
    end else if (trans) begin
      presc <= '0;
      timer <= '0;
    end else if (tick) begin
      presc <= '0;
      timer <= timer + TW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pedestrian request latch; entering WALK serves it and overrides a new press
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ped_q <= 1'b0;
    end else if ((cur_state == S_SY) && (nxt_state == S_WALK)) begin
      ped_q <= 1'b0;
    end else if (ped_req && (cur_state inside {S_MG, S_MY, S_SG, S_SY})) begin
      ped_q <= 1'b1;
    end
  end

  assign ped_wait = ped_q;
  assign state    = cur_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and random checks of traffic_light_ctrl against a phase/elapsed-clock
// reference model.
module tb_traffic_light_ctrl;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned T_GREEN_M = 5;
  localparam int unsigned T_GREEN_S = 3;
  localparam int unsigned T_YELLOW  = 2;
  localparam int unsigned T_WALK    = 4;

  localparam int P_MG = 0, P_MY = 1, P_SG = 2, P_SY = 3, P_WALK = 4;

  logic       clk;
  logic       rstn;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_wait;
  logic [2:0] state;

  traffic_light_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .T_GREEN_M(T_GREEN_M),
    .T_GREEN_S(T_GREEN_S),
    .T_YELLOW (T_YELLOW),
    .T_WALK   (T_WALK)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ped_req   (ped_req),
    .main_light(main_light),
    .side_light(side_light),
    .walk      (walk),
    .ped_wait  (ped_wait),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: current phase, clocks spent in it, pending request
  int m_ph  = P_MG;
  int m_cnt = 0;
  bit m_ped = 1'b0;

  int wrun = 0;
  int wnum = 0;

  function automatic int dur(input int ph);
    case (ph)
      P_MY, P_SY: return T_YELLOW * CLK_DIV;
      P_SG:       return T_GREEN_S * CLK_DIV;
      P_WALK:     return T_WALK * CLK_DIV;
      default:    return T_GREEN_M * CLK_DIV;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int ph);
    case (ph)
      P_MG:    return 3'b001;
      P_MY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int ph);
    case (ph)
      P_SG:    return 3'b001;
      P_SY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_reset();
    m_ph  = P_MG;
    m_cnt = 0;
    m_ped = 1'b0;
  endtask

  task automatic model_clk(input logic req);
    bit last;
    int nph;
    last = (m_cnt == dur(m_ph) - 1);
    nph  = m_ph;
    if (last) begin
      case (m_ph)
        P_MG:    nph = P_MY;
        P_MY:    nph = P_SG;
        P_SG:    nph = P_SY;
        P_SY:    nph = m_ped ? P_WALK : P_MG;
        default: nph = P_MG;
      endcase
    end
    if (nph == P_WALK && m_ph == P_SY) m_ped = 1'b0;
    else if (req && m_ph != P_WALK)    m_ped = 1'b1;
    m_cnt = last ? 0 : m_cnt + 1;
    m_ph  = nph;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state", 8'(state), 8'(m_ph));
    chk("main_light", 8'(main_light), 8'(exp_main(m_ph)));
    chk("side_light", 8'(side_light), 8'(exp_side(m_ph)));
    chk("walk", 8'(walk), 8'(m_ph == P_WALK));
    chk("ped_wait", 8'(ped_wait), 8'(m_ped));
    if (walk === 1'b1) begin
      wrun++;
    end else if (wrun > 0) begin
      chk("walk_len", 8'(wrun), 8'(T_WALK * CLK_DIV));
      wnum++;
      wrun = 0;
    end
  endtask

  // One clock: drive request at the falling edge, sample after the next fall
  task automatic cyc(input logic req);
    ped_req = req;
    @(posedge clk);
    model_clk(req);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic run_until(input int ph, input bit at_last, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_ph == ph && (!at_last || m_cnt == dur(ph) - 1)) begin
        hit = 1'b1;
        break;
      end
      cyc(1'b0);
    end
    chk(tag, 8'(hit), 8'd1);
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    #1;
    model_reset();
    wrun = 0;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rstn = 1'b1;
  endtask

  initial begin
    int w0;
    int mg;
    int hold;
    logic r;

    rstn    = 1'b0;
    ped_req = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rstn = 1'b1;

    // 1: free-running cycle without requests
    idle(T_GREEN_M * CLK_DIV);
    chk("s1_mg_len", 8'(state), 8'(P_MY));
    idle(48 - T_GREEN_M * CLK_DIV);
    chk("s1_back_mg", 8'(state), 8'(P_MG));

    // 2: request in the third clock of MG
    w0 = wnum;
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    chk("s2_ped_set", 8'(ped_wait), 8'd1);
    idle(61);
    chk("s2_one_walk", 8'(wnum - w0), 8'd1);
    chk("s2_back_mg", 8'(state), 8'(P_MG));

    // 3: press during WALK is ignored
    cyc(1'b1);
    run_until(P_WALK, 1'b0, "s3_reach_walk");
    cyc(1'b0);
    cyc(1'b1);
    chk("s3_ped_ignored", 8'(ped_wait), 8'd0);
    run_until(P_MG, 1'b0, "s3_reach_mg");
    w0 = wnum;
    idle(48);
    chk("s3_no_walk", 8'(wnum - w0), 8'd0);

    // 4: several presses collapse into one service
    w0 = wnum;
    cyc(1'b1);
    idle(3);
    cyc(1'b1);
    run_until(P_SG, 1'b0, "s4_reach_sg");
    cyc(1'b0);
    cyc(1'b1);
    run_until(P_MG, 1'b0, "s4_reach_mg");
    chk("s4_one_walk", 8'(wnum - w0), 8'd1);
    w0 = wnum;
    idle(48);
    chk("s4_no_walk", 8'(wnum - w0), 8'd0);

    // 5: press on the very clock SY hands over to WALK
    cyc(1'b1);
    run_until(P_SY, 1'b1, "s5_reach_sy_end");
    cyc(1'b1);
    chk("s5_in_walk", 8'(state), 8'(P_WALK));
    chk("s5_ped_clear", 8'(ped_wait), 8'd0);
    run_until(P_MG, 1'b0, "s5_reach_mg");
    w0 = wnum;
    idle(48);
    chk("s5_no_walk", 8'(wnum - w0), 8'd0);

    // 6: one-clock reset in the middle of SG
    cyc(1'b1);
    run_until(P_SG, 1'b0, "s6_reach_sg");
    idle(5);
    reset_pulse();
    mg = 0;
    while (state === 3'd0 && mg < 100) begin
      mg++;
      cyc(1'b0);
    end
    chk("s6_mg_len", 8'(mg), 8'(T_GREEN_M * CLK_DIV));

    // Random presses, including held-high bursts
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold > 0) begin
        hold--;
        r = 1'b1;
      end else if ($urandom_range(0, 24) == 0) begin
        hold = int'($urandom_range(0, 5));
        r = 1'b1;
      end else begin
        r = 1'b0;
      end
      cyc(r);
    end
    ped_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
